// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported, fixed-latency memory
// between the instruction-fetch (IF) and data-memory (DM) requesters.
// One access is in flight at a time. The winner receives a one-cycle ready
// pulse in the final cycle of its access.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  // The counter starts at MEM_LATENCY-1 so the access spans exactly
  // MEM_LATENCY busy cycles and ends on the cycle where it reads zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_lastGrant;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_busy;
  logic w_final;
  logic w_grantIf;
  logic w_grantDm;

  // On a tie, the side that did not win last time wins. A lone requester
  // always wins.
  assign w_grantIf = if_req && (!dm_req || r_lastGrant);
  assign w_grantDm = dm_req && (!if_req || !r_lastGrant);

  assign w_busy  = (r_state == BUSY_IF) || (r_state == BUSY_DM);
  assign w_final = w_busy && (r_cnt == 4'd0);

  // The memory port is driven only from the latches, and only while busy,
  // so the port reads zero while idle and live requester inputs cannot
  // disturb an access in flight.
  assign mem_en    = w_busy;
  assign mem_we    = w_busy ? r_we    : 1'b0;
  assign mem_be    = w_busy ? r_be    : '0;
  assign mem_addr  = w_busy ? r_addr  : '0;
  assign mem_wdata = w_busy ? r_wdata : '0;

  assign if_ready = w_final && (r_state == BUSY_IF);
  assign dm_ready = w_final && (r_state == BUSY_DM);
  assign if_rdata = if_ready            ? mem_rdata : '0;
  assign dm_rdata = (dm_ready && !r_we) ? mem_rdata : '0;

  // Arbitration FSM: accept one request in IDLE, latch it, and hold the
  // memory port for MEM_LATENCY cycles before returning to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_lastGrant <= 1'b1;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantIf) begin
            r_state     <= BUSY_IF;
            r_cnt       <= CNT_INIT;
            r_lastGrant <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= '1;
            r_addr      <= if_addr;
            r_wdata     <= '0;
          end else if (w_grantDm) begin
            r_state     <= BUSY_DM;
            r_cnt       <= CNT_INIT;
            r_lastGrant <= 1'b1;
            r_we        <= dm_we;
            r_be        <= dm_be;
            r_addr      <= dm_addr;
            r_wdata     <= dm_wdata;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (r_cnt == 4'd0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name:
mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM, loads/stores) of the RISC-V core. It latches one request at a time and drives the memory port for a fixed number of cycles. It pulses a one-cycle ready to the winning requester, which stalls until it sees ready. Simultaneous requests are resolved round-robin so neither side starves.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
MEM_LATENCY, 2, cycles mem_en must be held before mem_rdata is valid; legal range 1..15

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid only while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held until dm_ready
dm_we  in  1  1=store, 0=load
dm_be  in  DATA_W/8  store byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid only while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data access
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in the MEM_LATENCY-th cycle of mem_en

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM. Registers: state, cnt (4b), last_grant (0=IF, 1=DM), and latched we/be/addr/wdata.
- Reset (async, immediate): state=IDLE, cnt=0, last_grant=1 (IF wins the first tie), latches=0. All outputs read 0 during and after reset until a grant.
- IDLE, one requester active: at the clock edge, latch its addr (and dm_we/dm_be/dm_wdata for DM; IF forces we=0, be=all-ones), cnt=MEM_LATENCY-1, enter BUSY_x, last_grant=x.
- IDLE, both active: grant the side opposite to last_grant.
- IDLE, none active: stay in IDLE.
- BUSY_x: mem_en=1 and mem_we/be/addr/wdata are driven from the latches, not the live inputs. Decrement cnt each cycle while cnt!=0.
- BUSY_x with cnt==0 (final cycle): assert x_ready=1 combinationally. For a load or fetch, x_rdata=mem_rdata; for a store, dm_rdata=0. Next state is IDLE.
- Per-access latency: request seen in IDLE at edge k; ready high in cycle k+MEM_LATENCY; the requester's next request is sampled at edge k+MEM_LATENCY+1. Throughput is one access per MEM_LATENCY+1 cycles.
- Outside the final busy cycle, if_ready=dm_ready=0 and if_rdata=dm_rdata=0. Both readies are never high in the same cycle.
- A request deasserted mid-access is not cancelled. The access completes and ready still pulses.
- Changes to addr or data while BUSY do not affect the in-flight access.
- A request arriving while BUSY waits. It is evaluated in the next IDLE cycle under the round-robin rule.
- MEM_LATENCY=1: BUSY lasts exactly one cycle with ready high in that cycle.
- rst asserted mid-access: mem_en and ready drop immediately; the access is lost. The requester must re-issue after reset.

Test Plan:
- Reset with MEM_LATENCY=2, then if_req=1, if_addr=0x100, mem model returns 0x00500093: mem_en high for 2 cycles with mem_addr=0x100 and mem_we=0; if_ready pulses in the 2nd cycle with if_rdata=0x00500093; dm_ready stays 0.
- Store: dm_req=1, dm_we=1, dm_be=0xF, dm_addr=0x2000, dm_wdata=0xDEADBEEF: mem_we=1 with mem_addr=0x2000 for 2 cycles; dm_ready pulses once with dm_rdata=0; memory model holds 0xDEADBEEF.
- if_req and dm_req both held continuously from reset: grants alternate IF, DM, IF, DM; readies occur every 3 cycles; never both high in one cycle.
- During BUSY_DM (load, dm_addr=0x40), change dm_addr to 0x80 and drop dm_req: mem_addr stays 0x40 for the whole access; dm_ready still pulses with the data at 0x40.
- Assert rst in the 1st busy cycle of a fetch: mem_en=0 and if_ready=0 immediately; after release, the arbiter is in IDLE and a re-issued fetch completes normally.
- MEM_LATENCY=1 build, back-to-back dm loads at 0x0 and 0x4: each dm_ready arrives 1 cycle after acceptance, with 2-cycle spacing between the two completions.
